sha_msg_feeder: RTL and testbench

Front-end initiator for the SHA-256 hashing core. It accepts a message as a stream of big-endian 32-bit words, performs FIPS 180-4 padding and length append, and assembles 512-bit blocks. For each block it drives the core's `M`, `H_in` and `run` inputs, chains the core's `hash_fin` back as the next `H_in`, and presents the final 256-bit digest. It sits between the bus/DMA word stream and the `hashing` core.

---
 rtl/sha_msg_feeder.sv | 166 ++++++++++++++++
 tb/tb_sha_msg_feeder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_feeder.sv
// Purpose: pads a big-endian 32-bit word stream per SHA-256 rules, builds 512-bit blocks and sequences the hashing core.
// Latency: one cycle per padded word, core_run one cycle after core_ready in RUN, digest_valid one cycle after the final core_done.
// Backpressure: in_ready is high only while filling a block; core_run waits for core_ready.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_ready     - word handshake; in_data word, in_last end-of-message, in_nbytes bytes in last word (0 = 4)
//   core_M/core_H         - block and chaining value to the core, stable from core_run until core_done
//   core_run              - one-cycle start pulse; core_ready gates it
//   core_done/core_hash   - core result strobe and value
//   digest/digest_valid   - final digest (held) and its one-cycle update pulse
module sha_msg_feeder #(
  parameter logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_nbytes,
  output logic [511:0] core_M,
  output logic [255:0] core_H,
  output logic         core_run,
  input  logic         core_ready,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic [255:0] digest,
  output logic         digest_valid
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_RUN, S_WAIT} state_t;

  state_t         state_q;
  logic [31:0]    blk_q [16];
  logic [4:0]     idx_q;
  logic [255:0]   h_q;
  logic [63:0]    bitlen_q;
  logic           marker_done_q;
  logic           final_q;
  logic           msg_end_q;     // last input word has been accepted
  logic           len_fits_q;    // current block has room for the 64-bit length
  logic           active_q;      // holds in_ready low for the first cycle after reset
  logic           core_run_q;
  logic [255:0]   digest_q;
  logic           digest_valid_q;

  logic [31:0]    fill_word_d;
  logic [63:0]    fill_bits_d;
  logic           accept;

  assign in_ready     = (state_q == S_FILL) && active_q;
  assign accept       = in_valid && in_ready;
  assign core_H       = h_q;
  assign core_run     = core_run_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;

  always_comb begin
    core_M = '0;
    for (int i = 0; i < 16; i++) begin
      core_M[511-32*i -: 32] = blk_q[i];
    end
  end

  // A short last word gets its 0x80 marker in place of the first unused byte.
  always_comb begin
    fill_word_d = in_data;
    fill_bits_d = 64'd32;
    if (in_last && (in_nbytes != 2'd0)) begin
      fill_bits_d = {59'd0, in_nbytes, 3'd0};
      case (in_nbytes)
        2'd1:    fill_word_d = {in_data[31:24], 24'h800000};
        2'd2:    fill_word_d = {in_data[31:16], 16'h8000};
        default: fill_word_d = {in_data[31:8], 8'h80};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_FILL;
      for (int i = 0; i < 16; i++) blk_q[i] <= '0;
      idx_q          <= '0;
      h_q            <= IV;
      bitlen_q       <= '0;
      marker_done_q  <= 1'b0;
      final_q        <= 1'b0;
      msg_end_q      <= 1'b0;
      len_fits_q     <= 1'b0;
      active_q       <= 1'b0;
      core_run_q     <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      active_q       <= 1'b1;
      core_run_q     <= 1'b0;
      digest_valid_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (accept) begin
            blk_q[idx_q[3:0]] <= fill_word_d;
            idx_q             <= idx_q + 5'd1;
            bitlen_q          <= bitlen_q + fill_bits_d;
            if (in_last) begin
              msg_end_q <= 1'b1;
              if (in_nbytes != 2'd0) begin
                marker_done_q <= 1'b1;
                len_fits_q    <= (idx_q <= 5'd13);
              end
            end
            // A full buffer must be hashed first even if this was the last
            // word; the remaining padding then goes into a following block.
            if (idx_q == 5'd15) state_q <= S_RUN;
            else if (in_last)   state_q <= S_PAD;
          end
        end
        S_PAD: begin
          idx_q <= idx_q + 5'd1;
          if (!marker_done_q) begin
            blk_q[idx_q[3:0]] <= 32'h8000_0000;
            marker_done_q     <= 1'b1;
            len_fits_q        <= (idx_q <= 5'd13);
            if (idx_q == 5'd15) state_q <= S_RUN;
          end else if (len_fits_q && (idx_q == 5'd14)) begin
            blk_q[idx_q[3:0]] <= bitlen_q[63:32];
          end else if (len_fits_q && (idx_q == 5'd15)) begin
            blk_q[idx_q[3:0]] <= bitlen_q[31:0];
            final_q           <= 1'b1;
            state_q           <= S_RUN;
          end else begin
            blk_q[idx_q[3:0]] <= 32'h0;
            if (idx_q == 5'd15) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (core_ready) begin
            core_run_q <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        default: begin // S_WAIT
          if (core_done) begin
            idx_q <= '0;
            if (final_q) begin
              digest_q       <= core_hash;
              digest_valid_q <= 1'b1;
              h_q            <= IV;
              bitlen_q       <= '0;
              marker_done_q  <= 1'b0;
              final_q        <= 1'b0;
              msg_end_q      <= 1'b0;
              len_fits_q     <= 1'b0;
              state_q        <= S_FILL;
            end else begin
              h_q        <= core_hash;
              // Any follow-on pad block starts at word 0, so the length fits.
              len_fits_q <= 1'b1;
              state_q    <= msg_end_q ? S_PAD : S_FILL;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_feeder.sv
module tb_sha_msg_feeder;

  localparam logic [255:0] IV_C = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_nbytes;
  logic [511:0] core_M;
  logic [255:0] core_H;
  logic         core_run;
  logic         core_ready;
  logic         core_done;
  logic [255:0] core_hash;
  logic [255:0] digest;
  logic         digest_valid;

  sha_msg_feeder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
    .core_M(core_M), .core_H(core_H), .core_run(core_run), .core_ready(core_ready),
    .core_done(core_done), .core_hash(core_hash),
    .digest(digest), .digest_valid(digest_valid));

  always #5 clk = ~clk;

  typedef struct packed {
    int           nw;      // words sent
    logic [1:0]   nb;      // in_nbytes driven on every word
    logic [511:0] w;       // message words, word 0 at the top
    int           runs;    // expected core_run count
    logic [31:0]  len;     // expected word 15 of the final block
    logic         has_dig; // known digest available
    logic [255:0] dig;
  } vec_t;

  vec_t vt [4];

  int checks = 0;
  int errors = 0;
  int run_cnt = 0;
  int dv_cnt = 0;
  int rdy_viol = 0;
  int inr_viol = 0;
  bit hold_ready = 1'b0;
  logic [511:0] run_m    [64];
  logic [255:0] run_h    [64];
  logic [255:0] run_hash [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 compression used as the behavioural core.
  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  // Behavioural core: 4-cycle latency, logs every block it is started on.
  initial begin : core_model
    bit busy;
    int cnt;
    logic [255:0] pend;
    busy = 1'b0; cnt = 0; pend = '0;
    core_ready = 1'b0; core_done = 1'b0; core_hash = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (digest_valid) dv_cnt++;
      if (core_run) begin
        if (!core_ready) rdy_viol++;
        pend = sha_compress(core_H, core_M);
        if (run_cnt < 64) begin
          run_m[run_cnt] = core_M;
          run_h[run_cnt] = core_H;
          run_hash[run_cnt] = pend;
        end
        run_cnt++;
        busy = 1'b1;
        cnt = 4;
        core_ready = 1'b0;
      end else if (busy) begin
        if (in_ready) inr_viol++;
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_hash = pend;
          busy = 1'b0;
          core_ready = !hold_ready;
        end
      end else begin
        core_ready = !hold_ready;
      end
    end
  end

  task automatic send_msg(input vec_t v, input bit gaps);
    int t;
    for (int k = 0; k < v.nw; k++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = v.w[511-32*k -: 32];
      in_last = (k == v.nw - 1);
      in_nbytes = v.nb;
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        timeout("send_word");
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_nbytes = 2'd0;
  endtask

  task automatic wait_digest(input int dvb);
    int t;
    t = 0;
    while (dv_cnt <= dvb && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (dv_cnt <= dvb) timeout("wait_digest");
  endtask

  initial begin : stim
    logic [511:0] m56, m64;
    int base, dvb, last, t;

    m56 = {448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071, 64'h0};
    m64 = m56;
    m64[63:0] = 64'h6f707172_70717273;

    vt[0] = '{nw: 1, nb: 2'd3, w: {32'h61626300, 480'h0}, runs: 1, len: 32'h18, has_dig: 1'b1,
              dig: 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad};
    vt[1] = '{nw: 14, nb: 2'd0, w: m56, runs: 2, len: 32'h1C0, has_dig: 1'b1,
              dig: 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1};
    vt[2] = '{nw: 14, nb: 2'd3, w: m56, runs: 1, len: 32'h1B8, has_dig: 1'b0, dig: '0};
    vt[3] = '{nw: 16, nb: 2'd0, w: m64, runs: 2, len: 32'h200, has_dig: 1'b0, dig: '0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_digest_valid", digest_valid, 0);
    chk("rst_digest", digest, 0);
    chk("rst_core_M_zero", core_M == '0, 1);
    chk("rst_core_H", core_H, IV_C);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      base = run_cnt;
      dvb = dv_cnt;
      send_msg(vt[i], 1'b0);
      wait_digest(dvb);
      repeat (8) @(negedge clk);
      last = base + vt[i].runs - 1;
      if (last > 63) last = 63;
      chk($sformatf("v%0d_runs", i), run_cnt - base, vt[i].runs);
      chk($sformatf("v%0d_dv_count", i), dv_cnt - dvb, 1);
      chk($sformatf("v%0d_first_H", i), run_h[base], IV_C);
      if (vt[i].runs > 1)
        chk($sformatf("v%0d_chain_H", i), run_h[base+1], run_hash[base]);
      chk($sformatf("v%0d_len_word", i), run_m[last][31:0], vt[i].len);
      chk($sformatf("v%0d_len_hi", i), run_m[last][63:32], 0);
      chk($sformatf("v%0d_digest", i), digest, vt[i].has_dig ? vt[i].dig : run_hash[last]);
      case (i)
        0: begin
          chk("abc_w0", run_m[base][511:480], 32'h61626380);
          chk("abc_w1_14_zero", run_m[base][479:64] == '0, 1);
        end
        1: begin
          chk("m56_b1_w14", run_m[base][63:32], 32'h8000_0000);
          chk("m56_b1_w15", run_m[base][31:0], 0);
          chk("m56_b2_zero", run_m[base+1][511:32] == '0, 1);
        end
        2: begin
          chk("m55_w13", run_m[base][95:64], 32'h6e6f7080);
          chk("m55_w12", run_m[base][127:96], 32'h6d6e6f70);
        end
        default: begin
          chk("m64_b1_w15", run_m[base][31:0], 32'h70717273);
          chk("m64_b2_w0", run_m[base+1][511:480], 32'h8000_0000);
          chk("m64_b2_zero", run_m[base+1][479:64] == '0, 1);
        end
      endcase
    end

    // Core stalled while the first block sits in RUN, with random input gaps.
    hold_ready = 1'b1;
    repeat (2) @(negedge clk);
    base = run_cnt;
    dvb = dv_cnt;
    send_msg(vt[1], 1'b1);
    repeat (12) @(negedge clk);
    chk("stall_no_run", run_cnt - base, 0);
    chk("stall_in_ready", in_ready, 0);
    hold_ready = 1'b0;
    wait_digest(dvb);
    repeat (4) @(negedge clk);
    chk("stall_runs", run_cnt - base, 2);
    chk("stall_digest", digest, vt[1].dig);
    chk("run_without_ready", rdy_viol, 0);
    chk("in_ready_while_busy", inr_viol, 0);

    // Reset while the core is working on "abc"; its late core_done must be ignored.
    base = run_cnt;
    dvb = dv_cnt;
    send_msg(vt[0], 1'b0);
    t = 0;
    while (run_cnt <= base && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (run_cnt <= base) timeout("abort_run");
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_digest_cleared", digest, 0);
    chk("abort_core_H", core_H, IV_C);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_dv", dv_cnt - dvb, 0);
    chk("abort_digest_held", digest, 0);
    base = run_cnt;
    dvb = dv_cnt;
    send_msg(vt[0], 1'b0);
    wait_digest(dvb);
    repeat (4) @(negedge clk);
    chk("rehash_runs", run_cnt - base, 1);
    chk("rehash_H", run_h[base], IV_C);
    chk("rehash_digest", digest, vt[0].dig);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
